fbuf_wr_arbiter: RTL and testbench
==================================

FBUF_WR_ARBITER -- requirements
Module: fbuf_wr_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 12, width of one framebuffer pixel word.
REQ-002 Parameter ADDR_WIDTH, default 17, width of framebuffer word address.
REQ-003 Parameter FBUF_DEPTH, default 129600, number of framebuffer words swept by a clear.
REQ-004 Parameter CLEAR_IN_BLANK, default 1, restricts clear writes to cycles with eof=1 when 1.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 rst_n  input  1  synchronous, active-low reset.
REQ-007 eof  input  1  vertical-blanking flag from the video timing generator.
REQ-008 wr0_valid / wr1_valid  input  1 each  write request from requester 0 / 1.
REQ-009 wr0_addr / wr1_addr  input  ADDR_WIDTH each  target framebuffer address.
REQ-010 wr0_data / wr1_data  input  DATA_WIDTH each  pixel data.
REQ-011 wr0_ready / wr1_ready  output  1 each  combinational grant; transfer when valid and ready both high.
REQ-012 clear_start  input  1  single-cycle pulse requesting a full-buffer fill.
REQ-013 clear_value  input  DATA_WIDTH  fill value, sampled on accepted clear_start.
REQ-014 clear_busy  output  1  high while the clear sweep is in progress.
REQ-015 clear_done  output  1  one-cycle pulse when the sweep completes.
REQ-016 bram_we  output  1  registered write enable to framebuffer write port.
REQ-017 bram_addr  output  ADDR_WIDTH  registered write address.
REQ-018 bram_din  output  DATA_WIDTH  registered write data.

Function
REQ-019 States SHALL be IDLE and CLEAR; at most one BRAM write per cycle.
REQ-020 IDLE: only requester 0 valid -> wr0_ready=1; only requester 1 valid -> wr1_ready=1; neither valid -> both ready 0.
REQ-021 IDLE, both valid: grant the requester not granted on the most recent transfer (round-robin); last-grant pointer SHALL reset to "1" so requester 0 wins the first contention.
REQ-022 Last-grant pointer SHALL update only on a completed transfer.
REQ-023 Accepted transfer in cycle N SHALL produce bram_we=1 with that addr/data in cycle N+1 (latency 1); otherwise bram_we=0 in N+1.
REQ-024 clear_start in IDLE SHALL move to CLEAR next cycle, latch clear_value, set sweep counter to 0, raise clear_busy; a simultaneous requester transfer in that cycle SHALL still complete.
REQ-025 CLEAR: wr0_ready=wr1_ready=0 unconditionally.
REQ-026 CLEAR, write-eligible cycle (eof=1, or CLEAR_IN_BLANK=0): issue write of counter/latched value with latency 1, increment counter.
REQ-027 CLEAR, eof=0 with CLEAR_IN_BLANK=1: counter holds, bram_we=0 next cycle; sweep resumes at next blanking.
REQ-028 Write of address FBUF_DEPTH-1 SHALL end the sweep: return to IDLE next cycle, clear_busy=0, clear_done=1 for exactly one cycle, counter not wrapped beyond FBUF_DEPTH-1.
REQ-029 clear_start while in CLEAR SHALL be ignored (no restart, value unchanged).
REQ-030 Requester addresses SHALL pass unmodified; no range check against FBUF_DEPTH.

Reset
REQ-031 rst_n=0 at a clock edge SHALL force IDLE, counter 0, last-grant=1, bram_we=0, bram_addr=0, bram_din=0, clear_busy=0, clear_done=0; ready outputs 0 while rst_n=0.
REQ-032 Reset mid-sweep SHALL abort the clear with no clear_done pulse; no write issued in the cycle after reset.

Verification
REQ-033 wr0_valid only, addr=0x00010, data=0xABC -> wr0_ready=1, next cycle bram_we=1, addr=0x00010, din=0xABC.
REQ-034 Both valid held 4 cycles after reset -> grants 0,1,0,1; four BRAM writes on consecutive cycles.
REQ-035 CLEAR_IN_BLANK=1, FBUF_DEPTH=8, clear_start with value 0x000, eof low 5 cycles then high -> no writes while eof=0, then addresses 0..7 written, clear_done one cycle after address 7, wr*_ready=0 throughout.
REQ-036 eof toggled low after address 3 of sweep -> counter holds at 4, resumes at 4 when eof returns; no skipped or duplicate address.
REQ-037 rst_n pulsed low during sweep at address 5 -> bram_we=0, clear_busy=0, no clear_done; subsequent wr0 request granted normally.
REQ-038 clear_start reasserted with value 0xFFF mid-sweep -> ignored; all remaining writes use original value.

Source files
------------

// File: rtl/fbuf_wr_arbiter.sv
// Framebuffer write-port arbiter: two round-robin pixel requesters share a
// single BRAM write port with a full-buffer clear engine that can be limited
// to vertical blanking. All BRAM outputs are registered (latency 1).
module fbuf_wr_arbiter #(
    parameter int unsigned DATA_WIDTH     = 12,
    parameter int unsigned ADDR_WIDTH     = 17,
    parameter int unsigned FBUF_DEPTH     = 129600,
    parameter bit          CLEAR_IN_BLANK = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  eof,
    input  logic                  wr0_valid,
    input  logic [ADDR_WIDTH-1:0] wr0_addr,
    input  logic [DATA_WIDTH-1:0] wr0_data,
    output logic                  wr0_ready,
    input  logic                  wr1_valid,
    input  logic [ADDR_WIDTH-1:0] wr1_addr,
    input  logic [DATA_WIDTH-1:0] wr1_data,
    output logic                  wr1_ready,
    input  logic                  clear_start,
    input  logic [DATA_WIDTH-1:0] clear_value,
    output logic                  clear_busy,
    output logic                  clear_done,
    output logic                  bram_we,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [DATA_WIDTH-1:0] bram_din
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FBUF_DEPTH - 1);

    typedef enum logic [0:0] {StIdle, StClear} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  last_q, last_d;   // 1: requester 1 won the most recent transfer
    logic [DATA_WIDTH-1:0] val_q, val_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] din_q, din_d;
    logic                  done_q, done_d;
    logic                  clear_slot;

    // Grants: requesters only served in IDLE; on contention the one not served last wins.
    always_comb begin
        wr0_ready = 1'b0;
        wr1_ready = 1'b0;
        if (rst_n && (state_q == StIdle)) begin
            wr0_ready = wr0_valid && (!wr1_valid || last_q);
            wr1_ready = wr1_valid && (!wr0_valid || !last_q);
        end
    end

    assign clear_slot = eof || !CLEAR_IN_BLANK;

    // Next-state: arbitration/clear sweep and the registered BRAM write stage.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        val_d   = val_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        din_d   = din_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (wr0_ready) begin
                    we_d   = 1'b1;
                    addr_d = wr0_addr;
                    din_d  = wr0_data;
                    last_d = 1'b0;
                end else if (wr1_ready) begin
                    we_d   = 1'b1;
                    addr_d = wr1_addr;
                    din_d  = wr1_data;
                    last_d = 1'b1;
                end
                // A transfer in the same cycle still lands; the sweep starts next cycle.
                if (clear_start) begin
                    state_d = StClear;
                    val_d   = clear_value;
                    cnt_d   = '0;
                end
            end
            StClear: begin
                if (clear_slot) begin
                    we_d   = 1'b1;
                    addr_d = cnt_q;
                    din_d  = val_q;
                    if (cnt_q == LAST_ADDR) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + ADDR_WIDTH'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            last_q  <= 1'b1;
            val_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            val_q   <= val_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            done_q  <= done_d;
        end
    end

    assign clear_busy = (state_q == StClear);
    assign clear_done = done_q;
    assign bram_we    = we_q;
    assign bram_addr  = addr_q;
    assign bram_din   = din_q;

endmodule

// File: tb/tb_fbuf_wr_arbiter.sv
// Directed bench for fbuf_wr_arbiter with an 8-word buffer and blank-only clearing.
module tb_fbuf_wr_arbiter;

    localparam int unsigned DW = 12;
    localparam int unsigned AW = 17;

    logic          clk;
    logic          rst_n;
    logic          eof;
    logic          wr0_valid, wr1_valid;
    logic [AW-1:0] wr0_addr, wr1_addr;
    logic [DW-1:0] wr0_data, wr1_data;
    logic          wr0_ready, wr1_ready;
    logic          clear_start;
    logic [DW-1:0] clear_value;
    logic          clear_busy, clear_done;
    logic          bram_we;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_din;

    int vectors     = 0;
    int miscompares = 0;

    fbuf_wr_arbiter #(
        .DATA_WIDTH    (DW),
        .ADDR_WIDTH    (AW),
        .FBUF_DEPTH    (8),
        .CLEAR_IN_BLANK(1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .eof        (eof),
        .wr0_valid  (wr0_valid),
        .wr0_addr   (wr0_addr),
        .wr0_data   (wr0_data),
        .wr0_ready  (wr0_ready),
        .wr1_valid  (wr1_valid),
        .wr1_addr   (wr1_addr),
        .wr1_data   (wr1_data),
        .wr1_ready  (wr1_ready),
        .clear_start(clear_start),
        .clear_value(clear_value),
        .clear_busy (clear_busy),
        .clear_done (clear_done),
        .bram_we    (bram_we),
        .bram_addr  (bram_addr),
        .bram_din   (bram_din)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ready(input string tag, input logic r0, input logic r1);
        #1;
        chk({tag, ".r0"}, 32'(wr0_ready), 32'(r0));
        chk({tag, ".r1"}, 32'(wr1_ready), 32'(r1));
    endtask

    task automatic chk_wr(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] d);
        chk({tag, ".we"},   32'(bram_we),   32'h1);
        chk({tag, ".addr"}, 32'(bram_addr), 32'(a));
        chk({tag, ".din"},  32'(bram_din),  32'(d));
    endtask

    task automatic chk_flags(input string tag, input logic we, input logic busy, input logic done);
        chk({tag, ".we"},   32'(bram_we),    32'(we));
        chk({tag, ".busy"}, 32'(clear_busy), 32'(busy));
        chk({tag, ".done"}, 32'(clear_done), 32'(done));
    endtask

    initial begin
        rst_n = 1'b0; eof = 1'b0;
        wr0_valid = 1'b1; wr0_addr = '0; wr0_data = '0;
        wr1_valid = 1'b1; wr1_addr = '0; wr1_data = '0;
        clear_start = 1'b0; clear_value = '0;

        // Reset state, grants held low while in reset
        tick(); tick();
        chk_flags("rst", 1'b0, 1'b0, 1'b0);
        chk("rst.addr", 32'(bram_addr), 32'h0);
        chk("rst.din",  32'(bram_din),  32'h0);
        chk_ready("rst", 1'b0, 1'b0);

        // Contention held 4 cycles: grants 0,1,0,1 and back-to-back writes
        rst_n = 1'b1;
        wr0_addr = 17'h00100; wr0_data = 12'h111;
        wr1_addr = 17'h00200; wr1_data = 12'h222;
        for (int i = 0; i < 4; i++) begin
            chk_ready("rr", (i % 2) == 0, (i % 2) == 1);
            tick();
            if ((i % 2) == 0) chk_wr("rr.wr", 17'h00100, 12'h111);
            else              chk_wr("rr.wr", 17'h00200, 12'h222);
        end
        wr0_valid = 1'b0; wr1_valid = 1'b0;
        chk_ready("idle", 1'b0, 1'b0);
        tick();
        chk("idle.we", 32'(bram_we), 32'h0);

        // Single requester 0, then single requester 1 with an out-of-buffer address
        wr0_valid = 1'b1; wr0_addr = 17'h00010; wr0_data = 12'hABC;
        chk_ready("w0", 1'b1, 1'b0);
        tick();
        wr0_valid = 1'b0;
        chk_wr("w0.wr", 17'h00010, 12'hABC);
        wr1_valid = 1'b1; wr1_addr = 17'h1FFFF; wr1_data = 12'h5A5;
        chk_ready("w1", 1'b0, 1'b1);
        tick();
        wr1_valid = 1'b0;
        chk_wr("w1.wr", 17'h1FFFF, 12'h5A5);

        // clear_start with a concurrent requester-0 transfer
        clear_start = 1'b1; clear_value = 12'h000;
        wr0_valid = 1'b1; wr0_addr = 17'h00033; wr0_data = 12'h044;
        chk_ready("cs", 1'b1, 1'b0);
        tick();
        clear_start = 1'b0; clear_value = 12'hEEE;
        wr1_valid = 1'b1;
        chk_wr("cs.wr", 17'h00033, 12'h044);
        chk("cs.busy", 32'(clear_busy), 32'h1);

        // eof low for 5 cycles: no writes, no grants
        for (int i = 0; i < 5; i++) begin
            chk_ready("hold", 1'b0, 1'b0);
            tick();
            chk_flags("hold", 1'b0, 1'b1, 1'b0);
        end

        // Blanking: addresses 0..3
        eof = 1'b1;
        for (int a = 0; a < 4; a++) begin
            chk_ready("sw", 1'b0, 1'b0);
            tick();
            chk_wr("sw.wr", AW'(a), 12'h000);
        end

        // Blanking ends after address 3: counter holds
        eof = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_flags("pause", 1'b0, 1'b1, 1'b0);
        end

        // Resume at 4; restart attempt with 0xFFF is ignored
        eof = 1'b1;
        tick();
        chk_wr("res.wr", 17'd4, 12'h000);
        clear_start = 1'b1; clear_value = 12'hFFF;
        tick();
        clear_start = 1'b0;
        chk_wr("ign.wr", 17'd5, 12'h000);
        tick();
        chk_wr("sw6.wr", 17'd6, 12'h000);
        chk_flags("sw6", 1'b1, 1'b1, 1'b0);
        chk_ready("sw6", 1'b0, 1'b0);
        tick();
        wr0_valid = 1'b0; wr1_valid = 1'b0;
        chk_wr("sw7.wr", 17'd7, 12'h000);
        chk_flags("sw7", 1'b1, 1'b0, 1'b1);
        eof = 1'b0;
        tick();
        chk_flags("post", 1'b0, 1'b0, 1'b0);

        // New sweep, aborted by reset when address 5 is next
        eof = 1'b1;
        clear_start = 1'b1; clear_value = 12'h3C3;
        tick();
        clear_start = 1'b0;
        chk_flags("c2", 1'b0, 1'b1, 1'b0);
        for (int a = 0; a < 5; a++) begin
            tick();
            chk_wr("c2.wr", AW'(a), 12'h3C3);
        end
        rst_n = 1'b0;
        wr0_valid = 1'b1; wr0_addr = 17'h00007; wr0_data = 12'h123;
        chk_ready("arst", 1'b0, 1'b0);
        tick();
        chk_flags("arst", 1'b0, 1'b0, 1'b0);
        chk("arst.addr", 32'(bram_addr), 32'h0);
        chk("arst.din",  32'(bram_din),  32'h0);

        // After reset: requester 0 wins contention again
        rst_n = 1'b1;
        wr1_valid = 1'b1; wr1_addr = 17'h00009; wr1_data = 12'h456;
        chk_ready("prst", 1'b1, 1'b0);
        tick();
        wr0_valid = 1'b0; wr1_valid = 1'b0;
        chk_wr("prst.wr", 17'h00007, 12'h123);
        chk_flags("prst", 1'b1, 1'b0, 1'b0);
        tick();
        chk_flags("end", 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
